// File: rtl/rssb_pkg.sv
// Shared types and mux encodings for the RSSB multi-cycle controller and datapath.
package rssb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    READ,
    WRITE,
    PCUPD,
    ERROR
  } ctrl_state_t;

  localparam logic SEL_MEM_PC  = 1'b0;
  localparam logic SEL_MEM_OP1 = 1'b1;

  localparam logic SEL_PC_INC1 = 1'b0;
  localparam logic SEL_PC_INC2 = 1'b1;

endpackage

// File: rtl/rssb_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle whose wait would reach MAX_WAIT.
module rssb_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_cnt;
  logic              w_waiting;

  assign w_waiting = req & ~ready;
  // A ready in the final allowed cycle masks the timeout.
  assign timeout   = w_waiting & (r_cnt == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_waiting) begin
      r_cnt <= r_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/rssb_mc_control.sv
// Multi-cycle control FSM for the RSSB datapath (acc = mem[a] - acc; mem[a] = acc; skip on borrow).
// Define RSSB_PERF_CNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module rssb_mc_control
  import rssb_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_ready,
  input  logic             neg,
  output logic             mem_req,
  output logic             sel_mem,
  output logic             sel_pc,
  output logic             write_op1,
  output logic             write_acc,
  output logic             write_mem,
  output logic             write_pc,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  logic        r_neg_q;
  logic        r_error;
  logic        w_timeout;
  logic        w_clr;

  assign mem_req = (r_state == FETCH) || (r_state == READ) || (r_state == WRITE);
  assign busy    = (r_state != IDLE) && (r_state != ERROR);
  assign error   = r_error;
  assign w_clr   = (w_next != r_state);

  rssb_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .req     (mem_req),
    .ready   (mem_ready),
    .timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_neg_q <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == READ) && mem_ready) begin
        r_neg_q <= neg;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  // Next state and ready-gated datapath strobes.
  always_comb begin
    w_next    = r_state;
    sel_mem   = SEL_MEM_PC;
    sel_pc    = SEL_PC_INC1;
    write_op1 = 1'b0;
    write_acc = 1'b0;
    write_mem = 1'b0;
    write_pc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = FETCH;
        end
      end
      FETCH: begin
        sel_mem = SEL_MEM_PC;
        if (mem_ready) begin
          write_op1 = 1'b1;
          w_next    = READ;
        end else if (w_timeout) begin
          w_next = ERROR;
        end
      end
      READ: begin
        sel_mem = SEL_MEM_OP1;
        if (mem_ready) begin
          write_acc = 1'b1;
          w_next    = WRITE;
        end else if (w_timeout) begin
          w_next = ERROR;
        end
      end
      WRITE: begin
        sel_mem = SEL_MEM_OP1;
        if (mem_ready) begin
          write_mem = 1'b1;
          w_next    = PCUPD;
        end else if (w_timeout) begin
          w_next = ERROR;
        end else begin
          write_mem = 1'b1;
        end
      end
      PCUPD: begin
        write_pc = 1'b1;
        sel_pc   = r_neg_q ? SEL_PC_INC2 : SEL_PC_INC1;
        w_next   = halt_req ? IDLE : FETCH;
      end
      ERROR: begin
        w_next = ERROR;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

`ifdef RSSB_PERF_CNT_EN
  logic [CNT_W-1:0] r_instr_count;

  // One retirement per PCUPD cycle, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= '0;
    end else if (r_state == PCUPD) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_rssb_mc_control.sv
// Scoreboard bench for rssb_mc_control: per-cycle expected strobe vectors are queued by the
// stimulus process and compared by an independent monitor on the falling clock edge.
module tb_rssb_mc_control;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_WAIT = 4;

  // {mem_req, sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc, busy, error}
  localparam logic [8:0] V_IDLE    = 9'b000000000;
  localparam logic [8:0] V_FETCH_W = 9'b100000010;
  localparam logic [8:0] V_FETCH_R = 9'b100100010;
  localparam logic [8:0] V_READ_W  = 9'b110000010;
  localparam logic [8:0] V_READ_R  = 9'b110010010;
  localparam logic [8:0] V_WRITE   = 9'b110001010;
  localparam logic [8:0] V_PC1     = 9'b000000110;
  localparam logic [8:0] V_PC2     = 9'b001000110;
  localparam logic [8:0] V_ERR     = 9'b000000001;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             halt_req;
  logic             mem_ready;
  logic             neg;
  logic             mem_req;
  logic             sel_mem;
  logic             sel_pc;
  logic             write_op1;
  logic             write_acc;
  logic             write_mem;
  logic             write_pc;
  logic             busy;
  logic             error;
  logic [CNT_W-1:0] instr_count;

  typedef struct {
    string            name;
    logic [8:0]       vec;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ret  = 0;

  rssb_mc_control #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .mem_ready   (mem_ready),
    .neg         (neg),
    .mem_req     (mem_req),
    .sel_mem     (sel_mem),
    .sel_pc      (sel_pc),
    .write_op1   (write_op1),
    .write_acc   (write_acc),
    .write_mem   (write_mem),
    .write_pc    (write_pc),
    .busy        (busy),
    .error       (error),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef RSSB_PERF_CNT_EN
    return CNT_W'(n);
`else
    return (n < 0) ? CNT_W'(1) : '0;
`endif
  endfunction

  function automatic logic [8:0] obs();
    return {mem_req, sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc, busy, error};
  endfunction

  task automatic check(input string name, input logic [8:0] vec, input logic [CNT_W-1:0] cnt);
    checks++;
    if (obs() !== vec || instr_count !== cnt) begin
      errors++;
      $display("FAIL %s @%0t: got strobes=%b count=%0d, expected strobes=%b count=%0d",
               name, $time, obs(), instr_count, vec, cnt);
    end
  endtask

  // Monitor: one expected vector per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.name, e.vec, e.cnt);
    end
  end

  task automatic step(input string name, input logic st, input logic hr, input logic rdy,
                      input logic ng, input logic [8:0] vec);
    exp_t e;
    start     = st;
    halt_req  = hr;
    mem_ready = rdy;
    neg       = ng;
    e.name    = name;
    e.vec     = vec;
    e.cnt     = exp_cnt(n_ret);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic ng, input logic hr_pc);
    step("fetch", 1'b0, 1'b0, 1'b1, 1'b0, V_FETCH_R);
    step("read", 1'b0, 1'b0, 1'b1, ng, V_READ_R);
    step("write", 1'b0, 1'b0, 1'b1, 1'b0, V_WRITE);
    step(ng ? "pcupd_skip" : "pcupd_inc", 1'b0, hr_pc, 1'b1, 1'b0, ng ? V_PC2 : V_PC1);
    n_ret++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    halt_req  = 1'b0;
    mem_ready = 1'b0;
    neg       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, start ignored while in reset
    step("reset", 1'b1, 1'b0, 1'b1, 1'b0, V_IDLE);
    rst = 1'b0;
    step("idle_halt_ignored", 1'b0, 1'b1, 1'b1, 1'b0, V_IDLE);
    step("idle_start", 1'b1, 1'b0, 1'b1, 1'b0, V_IDLE);

    // Back-to-back instructions: no skip, then skip with latched borrow
    instr(1'b0, 1'b0);
    instr(1'b1, 1'b0);

    // Fetch waits 3 cycles; start while busy must be ignored
    repeat (3) step("fetch_wait", 1'b1, 1'b0, 1'b0, 1'b0, V_FETCH_W);
    step("fetch_ready", 1'b1, 1'b0, 1'b1, 1'b0, V_FETCH_R);
    step("read", 1'b0, 1'b0, 1'b1, 1'b0, V_READ_R);
    step("write", 1'b0, 1'b0, 1'b1, 1'b0, V_WRITE);
    step("pcupd", 1'b0, 1'b0, 1'b1, 1'b0, V_PC1);
    n_ret++;

    // Ready arrives on the last allowed READ cycle; WRITE holds write_mem while waiting
    step("fetch", 1'b0, 1'b0, 1'b1, 1'b0, V_FETCH_R);
    repeat (3) step("read_wait", 1'b0, 1'b0, 1'b0, 1'b1, V_READ_W);
    step("read_ready_at_max", 1'b0, 1'b0, 1'b1, 1'b1, V_READ_R);
    repeat (3) step("write_wait", 1'b0, 1'b0, 1'b0, 1'b0, V_WRITE);
    step("write_ready", 1'b0, 1'b0, 1'b1, 1'b0, V_WRITE);
    step("pcupd_skip", 1'b0, 1'b0, 1'b1, 1'b0, V_PC2);
    n_ret++;

    // Halt pulsed during WRITE only: instruction continues into FETCH
    step("fetch", 1'b0, 1'b0, 1'b1, 1'b0, V_FETCH_R);
    step("read", 1'b0, 1'b0, 1'b1, 1'b0, V_READ_R);
    step("write_halt", 1'b0, 1'b1, 1'b1, 1'b0, V_WRITE);
    step("pcupd_nohalt", 1'b0, 1'b0, 1'b1, 1'b0, V_PC1);
    n_ret++;

    // Halt held through PCUPD: return to IDLE
    instr(1'b0, 1'b1);
    repeat (2) step("halted", 1'b0, 1'b1, 1'b1, 1'b0, V_IDLE);
    step("restart", 1'b1, 1'b0, 1'b1, 1'b0, V_IDLE);

    // Run to 17 retired instructions to wrap the 4-bit counter
    for (int i = 0; i < 11; i++) instr(1'b0, (i == 10));
    step("wrapped", 1'b0, 1'b0, 1'b1, 1'b0, V_IDLE);

    // Timeout in READ
    step("to_start", 1'b1, 1'b0, 1'b1, 1'b0, V_IDLE);
    step("to_fetch", 1'b0, 1'b0, 1'b1, 1'b0, V_FETCH_R);
    repeat (4) step("to_read_wait", 1'b0, 1'b0, 1'b0, 1'b0, V_READ_W);
    repeat (3) step("error_sticky", 1'b1, 1'b0, 1'b1, 1'b0, V_ERR);

    // Only reset leaves ERROR
    rst   = 1'b1;
    n_ret = 0;
    #1;
    check("rst_clears_error", V_IDLE, exp_cnt(n_ret));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Async reset while write_mem is pending
    step("idle_start2", 1'b1, 1'b0, 1'b1, 1'b0, V_IDLE);
    step("fetch", 1'b0, 1'b0, 1'b1, 1'b0, V_FETCH_R);
    step("read", 1'b0, 1'b0, 1'b1, 1'b0, V_READ_R);
    start     = 1'b0;
    mem_ready = 1'b0;
    #2;
    check("write_pending", V_WRITE, exp_cnt(n_ret));
    rst = 1'b1;
    #1;
    check("rst_drops_write", V_IDLE, exp_cnt(n_ret));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("idle_after_rst", 1'b0, 1'b0, 1'b1, 1'b0, V_IDLE);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rssb_mc_control.md
Name: rssb_mc_control

Overview:
- Multi-cycle control FSM for the RSSB one-instruction datapath: acc = mem[a] - acc; mem[a] = acc; skip next instruction on borrow.
- Successor to the two-state controller.
- Adds a memory request/ready handshake, a parametrised wait-timeout, start/halt control, latched branch condition and a retired-instruction counter.
- Drives the existing datapath strobes: pc, op1, acc and mem registers, plus address/PC muxes.

Parameters:
- CNT_W, 16: width of retired-instruction counter instr_count.
- MAX_WAIT, 15: max cycles mem_req may stay high without mem_ready before error; legal range 1..255.
- WAIT_W, $clog2(MAX_WAIT+1): width of wait counter (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  leave IDLE and begin fetching at current PC
- halt_req  in  1  stop at next instruction boundary
- mem_ready  in  1  memory completes current access this cycle
- neg  in  1  datapath ALU borrow (mem[a] - acc < 0), valid in READ
- mem_req  out  1  memory access in progress
- sel_mem  out  1  memory address select: 0 = PC, 1 = op1
- sel_pc  out  1  PC increment select: 0 = +1, 1 = +2 (skip)
- write_op1  out  1  load op1 from memory read data
- write_acc  out  1  load acc from ALU result
- write_mem  out  1  memory write enable (data = ALU result)
- write_pc  out  1  load PC from incrementer
- busy  out  1  high in any state except IDLE and ERROR
- error  out  1  sticky memory-timeout flag
- instr_count  out  CNT_W  retired instructions

Behaviour:
- States, in package enum ctrl_state_t: IDLE, FETCH, READ, WRITE, PCUPD, ERROR.
- Reset: state = IDLE; neg_q = 0; wait_cnt = 0; instr_count = 0; error = 0; all strobes = 0.
- IDLE: all strobes 0. start=1 -> FETCH. halt_req is ignored in IDLE.
- FETCH: mem_req=1, sel_mem=0. On mem_ready: write_op1=1 (same cycle), -> READ.
- READ: mem_req=1, sel_mem=1. On mem_ready: write_acc=1, neg_q <= neg, -> WRITE.
- WRITE: mem_req=1, sel_mem=1, write_mem=1 for every cycle until mem_ready; on mem_ready -> PCUPD.
- PCUPD: write_pc=1, sel_pc=neg_q, mem_req=0, instr_count += 1 (wraps modulo 2^CNT_W). Next state is IDLE if halt_req=1 this cycle, else FETCH.
- Strobes are Moore outputs of the state, gated by mem_ready where noted above. No strobe is asserted outside its state.
- Minimum latency is 4 cycles per instruction (mem_ready tied high). Each wait cycle adds 1.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - If it reaches MAX_WAIT while mem_ready=0: -> ERROR, error <= 1, no strobe that cycle.
  - mem_ready in the same cycle the counter reaches MAX_WAIT wins: normal transition, no error.
- ERROR: all strobes 0, busy=0, error=1. Only rst exits.
- halt_req asserted mid-instruction: the instruction completes; the halt is sampled only in PCUPD.
- start while busy: ignored.
- rst mid-operation: immediate return to IDLE; any pending write_mem is dropped asynchronously.

Optional Feature:
- Macro RSSB_PERF_CNT_EN.
- Defined: instr_count implemented as above.
- Undefined: instr_count tied to 0 and the counter flops are removed; all other behaviour is identical.

Decomposition:
- rssb_pkg holds:
  - ctrl_state_t enum
  - SEL_MEM_PC = 1'b0, SEL_MEM_OP1 = 1'b1
  - SEL_PC_INC1 = 1'b0, SEL_PC_INC2 = 1'b1
- One sub-module, rssb_wait_timer (parameter MAX_WAIT):
  - inputs: clk, rst, clr, req, ready
  - output: timeout
  - instantiated once.

Test Plan:
- Ready tied high, start pulse, neg=0 in READ -> strobe sequence write_op1, write_acc, write_mem, write_pc on consecutive cycles; sel_pc=0; instr_count=1 after 4 cycles.
- Same as above with neg=1 in READ and neg=0 afterwards -> sel_pc=1 during PCUPD (latched value used).
- mem_ready delayed 3 cycles in FETCH -> write_op1 only on the ready cycle; instruction takes 7 cycles; error stays 0.
- MAX_WAIT=4, mem_ready held low in READ -> error=1 and busy=0 after 4 wait cycles; state stays ERROR until rst.
- halt_req pulsed during WRITE only -> instruction completes, then FETCH; halt_req held through PCUPD -> IDLE, busy=0.
- CNT_W=4, run 17 instructions -> instr_count=1 (wrap). With RSSB_PERF_CNT_EN undefined -> instr_count stays 0.
